// File: rtl/audio_pkg.sv
// audio_pkg: shared constants for the I2S codec slice.
//   DEF_DATA_WIDTH / DEF_SLOT_BITS : default sample width and BCLKs per slot
//   DEF_HYST_HI / DEF_HYST_LO      : default cassette comparator thresholds
//   MSB_POS / LSB_POS              : slot positions of the first/last data bit
package audio_pkg;

    localparam int DEF_DATA_WIDTH = 32'd16;
    localparam int DEF_SLOT_BITS  = 32'd32;

    localparam logic signed [15:0] DEF_HYST_HI = 16'sh2000;
    localparam logic signed [15:0] DEF_HYST_LO = -16'sh2000;

    // I2S: one BCLK of delay after the word-select edge, then MSB first.
    localparam int MSB_POS = 32'd1;
    localparam int LSB_POS = DEF_DATA_WIDTH;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } audio_ch_e;

    // True when a slot position carries a data bit for a dw-bit sample.
    function automatic logic slot_bit_active(input int cnt, input int dw);
        return (cnt >= MSB_POS) && (cnt <= dw);
    endfunction

endpackage

// File: rtl/audio_i2s_codec_if.sv
// audio_i2s_codec_if: playback sample-pair handshake bus.
//   iDAC_L / iDAC_R : sample pair from the producer
//   iDAC_VALID      : producer offers a pair
//   oDAC_READY      : codec pending buffer is free
// master = sample producer, slave = codec.
interface audio_i2s_codec_if
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] iDAC_L;
    logic [DATA_WIDTH-1:0] iDAC_R;
    logic                  iDAC_VALID;
    logic                  oDAC_READY;

    modport master (
        output iDAC_L,
        output iDAC_R,
        output iDAC_VALID,
        input  oDAC_READY
    );

    modport slave (
        input  iDAC_L,
        input  iDAC_R,
        input  iDAC_VALID,
        output oDAC_READY
    );
endinterface

// File: rtl/audio_hyst_cmp.sv
// audio_hyst_cmp: signed hysteresis comparator producing one cassette bit.
//   BCLK, iRST_N : clock, async active-low reset
//   i_valid      : new sample present this cycle
//   i_sample     : signed sample
//   o_cass       : 1 after a sample above HI, 0 after one below LO, else held
module audio_hyst_cmp
    import audio_pkg::*;
#(
    parameter int                           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic signed [DATA_WIDTH-1:0] HI         = DATA_WIDTH'(DEF_HYST_HI),
    parameter logic signed [DATA_WIDTH-1:0] LO         = DATA_WIDTH'(DEF_HYST_LO)
) (
    input  logic                         BCLK,
    input  logic                         iRST_N,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    output logic                         o_cass
);

    logic r_cass;

    // Threshold state update on each delivered sample; band between holds.
    always_ff @(posedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cass <= 1'b0;
        end else if (i_valid) begin
            if (i_sample > HI) begin
                r_cass <= 1'b1;
            end else if (i_sample < LO) begin
                r_cass <= 1'b0;
            end else begin
                r_cass <= r_cass;
            end
        end else begin
            r_cass <= r_cass;
        end
    end

    assign o_cass = r_cass;

endmodule

// File: rtl/audio_i2s_codec.sv
// audio_i2s_codec: I2S master-timed playback/capture with cassette comparators.
//   BCLK, iRST_N          : bit clock, async active-low reset
//   dac_bus (slave)       : playback pair handshake (iDAC_L/R, iDAC_VALID, oDAC_READY)
//   iMUTE                 : sampled at frame start, zeroes that frame
//   oUNDERRUN             : pulse when a frame starts with no new pair
//   oLRCK, oDACDAT        : word select / serial playback, launched on falling edge
//   iADCDAT               : serial capture
//   oADC_L/R, oADC_VALID  : captured pair, one pulse per frame
//   oCASS_L, oCASS_R      : per-channel hysteresis comparator bits
module audio_i2s_codec
    import audio_pkg::*;
#(
    parameter int               DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int               SLOT_BITS  = DEF_SLOT_BITS,
    parameter logic signed [15:0] HYST_HI  = DEF_HYST_HI,
    parameter logic signed [15:0] HYST_LO  = DEF_HYST_LO
) (
    input  logic                  BCLK,
    input  logic                  iRST_N,
    audio_i2s_codec_if.slave      dac_bus,
    input  logic                  iMUTE,
    output logic                  oUNDERRUN,
    output logic                  oLRCK,
    output logic                  oDACDAT,
    input  logic                  iADCDAT,
    output logic [DATA_WIDTH-1:0] oADC_L,
    output logic [DATA_WIDTH-1:0] oADC_R,
    output logic                  oADC_VALID,
    output logic                  oCASS_L,
    output logic                  oCASS_R
);

    localparam int                           CW       = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;
    localparam logic [CW-1:0]                CNT_LAST = CW'(SLOT_BITS - 1);
    localparam logic signed [DATA_WIDTH-1:0] HI_W     = DATA_WIDTH'(HYST_HI);
    localparam logic signed [DATA_WIDTH-1:0] LO_W     = DATA_WIDTH'(HYST_LO);

    logic [CW-1:0]         r_cnt;
    logic                  r_ch;
    logic [DATA_WIDTH-1:0] r_play_l, r_play_r;
    logic [DATA_WIDTH-1:0] r_pend_l, r_pend_r;
    logic                  r_dac_ready;     // 1 = pending buffer empty
    logic                  r_mute;
    logic                  r_underrun;
    logic [DATA_WIDTH-1:0] r_sh_l, r_sh_r;
    logic [DATA_WIDTH-1:0] r_adc_l, r_adc_r;
    logic                  r_adc_valid;
    logic                  r_lrck;
    logic                  r_dacdat;

    logic                  w_frame_start;
    logic                  w_accept;
    logic                  w_slot_bit;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_dac_bit;
    logic                  w_cass_l, w_cass_r;

    // Frame/handshake decode and the playback bit for the current slot position.
    always_comb begin
        w_frame_start = (r_cnt == CNT_LAST) && (r_ch == CH_RIGHT);
        w_accept      = dac_bus.iDAC_VALID && r_dac_ready;
        w_slot_bit    = slot_bit_active(int'(r_cnt), DATA_WIDTH);
        w_word        = (r_ch == CH_RIGHT) ? r_play_r : r_play_l;
        // Position 1 selects the MSB, so shift left by (cnt - 1).
        w_shifted     = w_word << (r_cnt - CW'(1));
        if (w_slot_bit && !r_mute) begin
            w_dac_bit = w_shifted[DATA_WIDTH-1];
        end else begin
            w_dac_bit = 1'b0;
        end
    end

    // Slot counter and channel toggle.
    always_ff @(posedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cnt <= {CW{1'b0}};
            r_ch  <= CH_LEFT;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= {CW{1'b0}};
            r_ch  <= ~r_ch;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            r_ch  <= r_ch;
        end
    end

    // Pending buffer, play registers, mute latch and underrun flag.
    // The frame-start decision looks only at pre-edge pending state, so a
    // pair accepted on that same edge lands in pending for the next frame.
    always_ff @(posedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_play_l    <= {DATA_WIDTH{1'b0}};
            r_play_r    <= {DATA_WIDTH{1'b0}};
            r_pend_l    <= {DATA_WIDTH{1'b0}};
            r_pend_r    <= {DATA_WIDTH{1'b0}};
            r_dac_ready <= 1'b1;
            r_mute      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= w_frame_start && r_dac_ready;
            if (w_frame_start) begin
                r_mute <= iMUTE;
            end else begin
                r_mute <= r_mute;
            end
            // A muted frame leaves a full pending buffer untouched.
            if (w_frame_start && !r_dac_ready && !iMUTE) begin
                r_play_l    <= r_pend_l;
                r_play_r    <= r_pend_r;
                r_dac_ready <= 1'b1;
            end else if (w_accept) begin
                r_pend_l    <= dac_bus.iDAC_L;
                r_pend_r    <= dac_bus.iDAC_R;
                r_dac_ready <= 1'b0;
            end else begin
                r_dac_ready <= r_dac_ready;
            end
        end
    end

    // Capture shift registers and per-frame captured-pair output.
    always_ff @(posedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sh_l      <= {DATA_WIDTH{1'b0}};
            r_sh_r      <= {DATA_WIDTH{1'b0}};
            r_adc_l     <= {DATA_WIDTH{1'b0}};
            r_adc_r     <= {DATA_WIDTH{1'b0}};
            r_adc_valid <= 1'b0;
        end else begin
            if (w_slot_bit && (r_ch == CH_RIGHT)) begin
                r_sh_r <= {r_sh_r[DATA_WIDTH-2:0], iADCDAT};
            end else if (w_slot_bit) begin
                r_sh_l <= {r_sh_l[DATA_WIDTH-2:0], iADCDAT};
            end else begin
                r_sh_l <= r_sh_l;
                r_sh_r <= r_sh_r;
            end
            if (w_frame_start) begin
                r_adc_l     <= r_sh_l;
                r_adc_r     <= r_sh_r;
                r_adc_valid <= 1'b1;
            end else begin
                r_adc_valid <= 1'b0;
            end
        end
    end

    // Falling-edge launch gives the codec half a BCLK of setup and hold.
    always_ff @(negedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_lrck   <= 1'b0;
            r_dacdat <= 1'b0;
        end else begin
            r_lrck   <= r_ch;
            r_dacdat <= w_dac_bit;
        end
    end

    audio_hyst_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .HI         (HI_W),
        .LO         (LO_W)
    ) u_cmp_l (
        .BCLK     (BCLK),
        .iRST_N   (iRST_N),
        .i_valid  (r_adc_valid),
        .i_sample (r_adc_l),
        .o_cass   (w_cass_l)
    );

    audio_hyst_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .HI         (HI_W),
        .LO         (LO_W)
    ) u_cmp_r (
        .BCLK     (BCLK),
        .iRST_N   (iRST_N),
        .i_valid  (r_adc_valid),
        .i_sample (r_adc_r),
        .o_cass   (w_cass_r)
    );

    assign dac_bus.oDAC_READY = r_dac_ready;
    assign oUNDERRUN          = r_underrun;
    assign oLRCK              = r_lrck;
    assign oDACDAT            = r_dacdat;
    assign oADC_L             = r_adc_l;
    assign oADC_R             = r_adc_r;
    assign oADC_VALID         = r_adc_valid;
    assign oCASS_L            = w_cass_l;
    assign oCASS_R            = w_cass_r;

endmodule

// File: tb/tb_audio_i2s_codec.sv
module tb_audio_i2s_codec;

    logic        BCLK = 1'b0;
    logic        iRST_N = 1'b1;
    logic        iMUTE = 1'b0;
    logic        r_loop = 1'b0;
    logic        r_adc_bit = 1'b0;
    logic        w_adcdat;
    logic        oUNDERRUN, oLRCK, oDACDAT, oADC_VALID, oCASS_L, oCASS_R;
    logic [15:0] oADC_L, oADC_R;

    int n_total = 0;
    int n_bad   = 0;
    int tb_pos  = 0;   // frame position (0..63) the DUT is in during this cycle

    audio_i2s_codec_if #(.DATA_WIDTH(16)) dac_if ();

    assign w_adcdat = r_loop ? oDACDAT : r_adc_bit;

    audio_i2s_codec dut (
        .BCLK       (BCLK),
        .iRST_N     (iRST_N),
        .dac_bus    (dac_if),
        .iMUTE      (iMUTE),
        .oUNDERRUN  (oUNDERRUN),
        .oLRCK      (oLRCK),
        .oDACDAT    (oDACDAT),
        .iADCDAT    (w_adcdat),
        .oADC_L     (oADC_L),
        .oADC_R     (oADC_R),
        .oADC_VALID (oADC_VALID),
        .oCASS_L    (oCASS_L),
        .oCASS_R    (oCASS_R)
    );

    always #5 BCLK = ~BCLK;

    task automatic tick();
        @(posedge BCLK);
        #1;
        tb_pos = (tb_pos + 1) % 64;
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        dac_if.iDAC_VALID = 1'b0;
        dac_if.iDAC_L = 16'h0;
        dac_if.iDAC_R = 16'h0;
        iMUTE = 1'b0;
        r_loop = 1'b0;
        r_adc_bit = 1'b0;
        repeat (2) @(posedge BCLK);
        #1;
        iRST_N = 1'b1;
        tb_pos = 0;
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        for (int k = 0; k < 200 && oDAC_READY_s() !== 1'b1; k++) tick();
        n_total++;
        if (oDAC_READY_s() !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready_timeout got=%b exp=1", oDAC_READY_s());
        end else begin
            dac_if.iDAC_L = l;
            dac_if.iDAC_R = r;
            dac_if.iDAC_VALID = 1'b1;
            tick();
            dac_if.iDAC_VALID = 1'b0;
        end
    endtask

    function automatic logic oDAC_READY_s();
        return dac_if.oDAC_READY;
    endfunction

    task automatic run_to_pos0();
        while (tb_pos != 0) tick();
    endtask

    // Capture one full frame starting at position 0; first bit lands in [63].
    task automatic record_frame(output logic [63:0] dac, output logic [63:0] lrck,
                                output int n_valid, output int n_under, output int n_ready);
        n_valid = 0; n_under = 0; n_ready = 0;
        for (int p = 0; p < 64; p++) begin
            if (oADC_VALID === 1'b1) n_valid++;
            if (oUNDERRUN === 1'b1) n_under++;
            if (dac_if.oDAC_READY === 1'b1) n_ready++;
            #5;
            dac[63-p]  = oDACDAT;
            lrck[63-p] = oLRCK;
            tick();
        end
    endtask

    // Drive I2S capture bits until the next frame start; non-data slots get 1.
    task automatic drive_adc_to_pos0(input logic [15:0] l, input logic [15:0] r);
        int c;
        logic [15:0] w;
        do begin
            c = tb_pos % 32;
            w = (tb_pos < 32) ? l : r;
            r_adc_bit = (c >= 1 && c <= 16) ? w[16-c] : 1'b1;
            tick();
        end while (tb_pos != 0);
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        @(posedge BCLK);
        #1;
        n_total += 9;
        if (oLRCK !== 1'b0)   begin n_bad++; $display("FAIL rst_lrck got=%b exp=0", oLRCK); end
        if (oDACDAT !== 1'b0) begin n_bad++; $display("FAIL rst_dacdat got=%b exp=0", oDACDAT); end
        if (dac_if.oDAC_READY !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", dac_if.oDAC_READY); end
        if (oUNDERRUN !== 1'b0)  begin n_bad++; $display("FAIL rst_underrun got=%b exp=0", oUNDERRUN); end
        if (oADC_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_adc_valid got=%b exp=0", oADC_VALID); end
        if (oADC_L !== 16'h0) begin n_bad++; $display("FAIL rst_adc_l got=%h exp=0000", oADC_L); end
        if (oADC_R !== 16'h0) begin n_bad++; $display("FAIL rst_adc_r got=%h exp=0000", oADC_R); end
        if (oCASS_L !== 1'b0) begin n_bad++; $display("FAIL rst_cass_l got=%b exp=0", oCASS_L); end
        if (oCASS_R !== 1'b0) begin n_bad++; $display("FAIL rst_cass_r got=%b exp=0", oCASS_R); end
    endtask

    task automatic test_playback_loopback();
        logic [63:0] dac, lrck;
        int nv, nu, nr;
        do_reset();
        r_loop = 1'b1;
        tick(); tick();
        send_pair(16'h6000, 16'hA000);
        n_total++;
        if (dac_if.oDAC_READY !== 1'b0) begin n_bad++; $display("FAIL pb_ready_drop got=%b exp=0", dac_if.oDAC_READY); end
        run_to_pos0();
        n_total += 2;
        if (dac_if.oDAC_READY !== 1'b1) begin n_bad++; $display("FAIL pb_ready_rise got=%b exp=1", dac_if.oDAC_READY); end
        if (oUNDERRUN !== 1'b0) begin n_bad++; $display("FAIL pb_no_underrun got=%b exp=0", oUNDERRUN); end
        record_frame(dac, lrck, nv, nu, nr);
        n_total += 3;
        if (dac !== 64'h3000_0000_5000_0000) begin n_bad++; $display("FAIL pb_dacdat got=%h exp=3000000050000000", dac); end
        if (lrck !== 64'h0000_0000_FFFF_FFFF) begin n_bad++; $display("FAIL pb_lrck got=%h exp=00000000ffffffff", lrck); end
        if (nv != 1) begin n_bad++; $display("FAIL pb_valid_count got=%0d exp=1", nv); end
        n_total += 4;
        if (oADC_VALID !== 1'b1) begin n_bad++; $display("FAIL lb_valid got=%b exp=1", oADC_VALID); end
        if (oADC_L !== 16'h6000) begin n_bad++; $display("FAIL lb_adc_l got=%h exp=6000", oADC_L); end
        if (oADC_R !== 16'hA000) begin n_bad++; $display("FAIL lb_adc_r got=%h exp=a000", oADC_R); end
        if (oUNDERRUN !== 1'b1) begin n_bad++; $display("FAIL lb_underrun got=%b exp=1", oUNDERRUN); end
        tick();
        n_total += 4;
        if (oADC_VALID !== 1'b0) begin n_bad++; $display("FAIL lb_valid_pulse got=%b exp=0", oADC_VALID); end
        if (oUNDERRUN !== 1'b0) begin n_bad++; $display("FAIL lb_underrun_pulse got=%b exp=0", oUNDERRUN); end
        if (oCASS_L !== 1'b1) begin n_bad++; $display("FAIL lb_cass_l got=%b exp=1", oCASS_L); end
        if (oCASS_R !== 1'b0) begin n_bad++; $display("FAIL lb_cass_r got=%b exp=0", oCASS_R); end
    endtask

    task automatic test_underrun_back_to_back();
        logic [63:0] dac, lrck;
        int nv, nu, nr;
        do_reset();
        tick();
        send_pair(16'h1234, 16'h4321);
        run_to_pos0();
        n_total++;
        if (oUNDERRUN !== 1'b0) begin n_bad++; $display("FAIL ur_first got=%b exp=0", oUNDERRUN); end
        record_frame(dac, lrck, nv, nu, nr);
        n_total += 2;
        if (dac !== 64'h091A_0000_2190_8000) begin n_bad++; $display("FAIL ur_play got=%h exp=091a000021908000", dac); end
        if (oUNDERRUN !== 1'b1) begin n_bad++; $display("FAIL ur_pulse got=%b exp=1", oUNDERRUN); end
        record_frame(dac, lrck, nv, nu, nr);
        n_total += 2;
        if (dac !== 64'h091A_0000_2190_8000) begin n_bad++; $display("FAIL ur_replay got=%h exp=091a000021908000", dac); end
        if (nu != 1) begin n_bad++; $display("FAIL ur_pulse_count got=%0d exp=1", nu); end
        while (tb_pos != 63) tick();
        dac_if.iDAC_L = 16'h5555;
        dac_if.iDAC_R = 16'h0AAA;
        dac_if.iDAC_VALID = 1'b1;
        tick();
        dac_if.iDAC_VALID = 1'b0;
        n_total += 2;
        if (oUNDERRUN !== 1'b1) begin n_bad++; $display("FAIL fs_hs_underrun got=%b exp=1", oUNDERRUN); end
        if (dac_if.oDAC_READY !== 1'b0) begin n_bad++; $display("FAIL fs_hs_ready got=%b exp=0", dac_if.oDAC_READY); end
        record_frame(dac, lrck, nv, nu, nr);
        n_total += 3;
        if (dac !== 64'h091A_0000_2190_8000) begin n_bad++; $display("FAIL fs_hs_old got=%h exp=091a000021908000", dac); end
        if (oUNDERRUN !== 1'b0) begin n_bad++; $display("FAIL fs_hs_next_ur got=%b exp=0", oUNDERRUN); end
        if (dac_if.oDAC_READY !== 1'b1) begin n_bad++; $display("FAIL fs_hs_next_ready got=%b exp=1", dac_if.oDAC_READY); end
        record_frame(dac, lrck, nv, nu, nr);
        n_total++;
        if (dac !== 64'h2AAA_8000_0555_0000) begin n_bad++; $display("FAIL fs_hs_new got=%h exp=2aaa800005550000", dac); end
    endtask

    task automatic test_cassette();
        logic [15:0] sl [6] = '{16'h1000, 16'h3000, 16'h1000, 16'hF000, 16'hD000, 16'h2000};
        logic [15:0] sr [6] = '{16'h3000, 16'h1000, 16'hD000, 16'h1000, 16'h3000, 16'hE000};
        logic        el [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        er [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_adc_to_pos0(sl[i], sr[i]);
            n_total += 3;
            if (oADC_VALID !== 1'b1) begin n_bad++; $display("FAIL cap_valid[%0d] got=%b exp=1", i, oADC_VALID); end
            if (oADC_L !== sl[i]) begin n_bad++; $display("FAIL cap_l[%0d] got=%h exp=%h", i, oADC_L, sl[i]); end
            if (oADC_R !== sr[i]) begin n_bad++; $display("FAIL cap_r[%0d] got=%h exp=%h", i, oADC_R, sr[i]); end
            r_adc_bit = 1'b1;
            tick();
            n_total += 2;
            if (oCASS_L !== el[i]) begin n_bad++; $display("FAIL cass_l[%0d] got=%b exp=%b", i, oCASS_L, el[i]); end
            if (oCASS_R !== er[i]) begin n_bad++; $display("FAIL cass_r[%0d] got=%b exp=%b", i, oCASS_R, er[i]); end
        end
    endtask

    task automatic test_mute();
        logic [63:0] dac, lrck;
        int nv, nu, nr;
        do_reset();
        tick();
        send_pair(16'h6000, 16'hA000);
        iMUTE = 1'b1;
        run_to_pos0();
        iMUTE = 1'b0;
        n_total += 2;
        if (dac_if.oDAC_READY !== 1'b0) begin n_bad++; $display("FAIL mute_ready got=%b exp=0", dac_if.oDAC_READY); end
        if (oUNDERRUN !== 1'b0) begin n_bad++; $display("FAIL mute_underrun got=%b exp=0", oUNDERRUN); end
        record_frame(dac, lrck, nv, nu, nr);
        n_total += 4;
        if (dac !== 64'h0) begin n_bad++; $display("FAIL mute_zero got=%h exp=0000000000000000", dac); end
        if (nr != 0) begin n_bad++; $display("FAIL mute_ready_held got=%0d exp=0", nr); end
        if (dac_if.oDAC_READY !== 1'b1) begin n_bad++; $display("FAIL unmute_ready got=%b exp=1", dac_if.oDAC_READY); end
        if (oUNDERRUN !== 1'b0) begin n_bad++; $display("FAIL unmute_underrun got=%b exp=0", oUNDERRUN); end
        record_frame(dac, lrck, nv, nu, nr);
        n_total++;
        if (dac !== 64'h3000_0000_5000_0000) begin n_bad++; $display("FAIL unmute_play got=%h exp=3000000050000000", dac); end
    endtask

    task automatic test_reset_midframe();
        int first;
        do_reset();
        r_loop = 1'b1;
        tick();
        send_pair(16'h7FFF, 16'h7FFF);
        run_to_pos0();
        tick();
        run_to_pos0();
        tick();
        n_total++;
        if (oCASS_L !== 1'b1) begin n_bad++; $display("FAIL mid_cass_pre got=%b exp=1", oCASS_L); end
        while (tb_pos != 10) tick();
        #5;
        n_total += 2;
        if (oDACDAT !== 1'b1) begin n_bad++; $display("FAIL mid_dacdat_pre got=%b exp=1", oDACDAT); end
        if (oADC_L !== 16'h7FFF) begin n_bad++; $display("FAIL mid_adc_pre got=%h exp=7fff", oADC_L); end
        iRST_N = 1'b0;
        #1;
        n_total += 9;
        if (oLRCK !== 1'b0)   begin n_bad++; $display("FAIL mid_lrck got=%b exp=0", oLRCK); end
        if (oDACDAT !== 1'b0) begin n_bad++; $display("FAIL mid_dacdat got=%b exp=0", oDACDAT); end
        if (dac_if.oDAC_READY !== 1'b1) begin n_bad++; $display("FAIL mid_ready got=%b exp=1", dac_if.oDAC_READY); end
        if (oUNDERRUN !== 1'b0)  begin n_bad++; $display("FAIL mid_underrun got=%b exp=0", oUNDERRUN); end
        if (oADC_VALID !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b exp=0", oADC_VALID); end
        if (oADC_L !== 16'h0) begin n_bad++; $display("FAIL mid_adc_l got=%h exp=0000", oADC_L); end
        if (oADC_R !== 16'h0) begin n_bad++; $display("FAIL mid_adc_r got=%h exp=0000", oADC_R); end
        if (oCASS_L !== 1'b0) begin n_bad++; $display("FAIL mid_cass_l got=%b exp=0", oCASS_L); end
        if (oCASS_R !== 1'b0) begin n_bad++; $display("FAIL mid_cass_r got=%b exp=0", oCASS_R); end
        @(posedge BCLK);
        #1;
        iRST_N = 1'b1;
        tb_pos = 0;
        first = -1;
        for (int p = 0; p < 64; p++) begin
            #5;
            if (oLRCK === 1'b1 && first < 0) first = p;
            tick();
        end
        n_total += 2;
        if (first != 32) begin n_bad++; $display("FAIL mid_lrck_first got=%0d exp=32", first); end
        if (oUNDERRUN !== 1'b1) begin n_bad++; $display("FAIL mid_first_underrun got=%b exp=1", oUNDERRUN); end
    endtask

    initial begin
        dac_if.iDAC_VALID = 1'b0;
        dac_if.iDAC_L = 16'h0;
        dac_if.iDAC_R = 16'h0;
        test_reset();
        test_playback_loopback();
        test_underrun_back_to_back();
        test_cassette();
        test_mute();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_i2s_codec.md
AUDIO_I2S_CODEC -- requirements
Module: audio_i2s_codec

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width, two's complement; range 8..24.
REQ-002 Parameter SLOT_BITS, default 32: BCLK periods per channel slot; SLOT_BITS >= DATA_WIDTH+1 is required.
REQ-003 Parameter HYST_HI, default 16'sh2000: signed cassette rising threshold.
REQ-004 Parameter HYST_LO, default -16'sh2000: signed cassette falling threshold; HYST_LO <= HYST_HI is required.
REQ-005 BCLK  in  1  bit clock; all state on rising edge except REQ-012.
REQ-006 iRST_N  in  1  reset, asynchronous, active-low.
REQ-007 iDAC_L, iDAC_R  in  DATA_WIDTH each  playback sample pair; iDAC_VALID  in  1  pair offered; oDAC_READY  out  1  pair buffer free.
REQ-008 iMUTE  in  1  force silent playback; oUNDERRUN  out  1  one-cycle pulse, frame played without a new pair.
REQ-009 oLRCK  out  1  word select, 0 = left; oDACDAT  out  1  serial playback; iADCDAT  in  1  serial capture.
REQ-010 oADC_L, oADC_R  out  DATA_WIDTH each  captured pair; oADC_VALID  out  1  one-cycle pulse.
REQ-011 oCASS_L, oCASS_R  out  1 each  hysteresis-comparator cassette bits.

Function
REQ-012 oLRCK and oDACDAT launch from falling-edge registers fed by rising-edge state, giving the codec a half-period of setup and hold.
REQ-013 Slot counter cnt counts 0..SLOT_BITS-1, then wraps to 0 and toggles channel ch; oLRCK = ch; frame = left slot then right slot = 2*SLOT_BITS BCLK.
REQ-014 I2S format: MSB at cnt==1, LSB at cnt==DATA_WIDTH, oDACDAT 0 for cnt==0 and cnt>DATA_WIDTH.
REQ-015 Handshake: a pair is accepted in any cycle with iDAC_VALID && oDAC_READY; it fills a single pending buffer and oDAC_READY drops the next cycle.
REQ-016 Frame start = cycle where cnt wraps to 0 and ch becomes 0. If pending is full, pending moves to the play registers and oDAC_READY rises the next cycle.
REQ-017 Frame start with pending empty: play registers hold the previous pair and oUNDERRUN pulses for one cycle.
REQ-018 Frame start uses the pending state from before the edge. A pair accepted in that same cycle is kept for the following frame, and REQ-017 applies.
REQ-019 iMUTE sampled at frame start: when 1, that frame plays zero in both slots. The pending buffer and handshake are unaffected; no underrun flagged for a full pending.
REQ-020 Capture samples iADCDAT at cnt 1..DATA_WIDTH, MSB first, into the channel's shift register; other bits are ignored.
REQ-021 In the cycle after the right-slot cnt==SLOT_BITS-1, oADC_L/oADC_R load the captured pair and oADC_VALID pulses once per frame.
REQ-022 Comparator per channel, updated one cycle after oADC_VALID: signed sample > HYST_HI sets 1; sample < HYST_LO clears 0; otherwise holds.
REQ-023 Comparator thresholds are sign-extended or truncated to DATA_WIDTH.

Reset
REQ-024 iRST_N low asynchronously forces cnt=0, ch=0, oLRCK=0, oDACDAT=0.
REQ-025 It also clears play and pending registers to 0, sets oDAC_READY=1, and sets oUNDERRUN, oADC_VALID, oADC_L/R, oCASS_L/R and shift registers to 0.
REQ-026 Reset mid-frame abandons the partial frame; first frame after release starts at left slot cnt=0, and oUNDERRUN pulses if no pair has arrived.

Structure
REQ-027 Shared package audio_pkg holds default DATA_WIDTH, SLOT_BITS, threshold constants, and the slot-position constants MSB_POS=1 and LSB_POS=DATA_WIDTH.
REQ-028 One sub-module audio_hyst_cmp (DATA_WIDTH, HI, LO) is instantiated once per channel; the rest is flat.

Verification
REQ-029 Defaults, pair L=16'h6000 R=16'hA000 accepted before frame -> left-slot bits 1..16 = 0110_0000_0000_0000, right = 1010_0000_0000_0000; bits 0 and 17..31 = 0.
REQ-030 Loopback iADCDAT=oDACDAT, pair as REQ-029 -> oADC_L=16'h6000, oADC_R=16'hA000; oADC_VALID exactly once per 64 BCLK.
REQ-031 No iDAC_VALID for one frame after pair 16'h1234/16'h4321 -> pair replayed, oUNDERRUN single pulse at frame start; handshake at frame-start cycle -> underrun, then played next frame.
REQ-032 ADC samples 16'h1000, 16'h3000, 16'h1000, 16'hF000, 16'hD000 -> oCASS 0,1,1,1,0.
REQ-033 iRST_N low at left cnt=10 -> all outputs at REQ-024/REQ-025 values immediately; after release, oLRCK first toggles 32 BCLK later.
REQ-034 iMUTE=1 at frame start with pending full -> zero frame, oDAC_READY stays 0 until the next unmuted frame start.
